onewire_master: RTL and testbench



---
 rtl/onewire_pkg.sv | 34 +++
 rtl/onewire_tick.sv | 37 +++
 rtl/onewire_master.sv | 172 +++++++++++++++++
 tb/tb_onewire_master.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/onewire_pkg.sv
// +------------------------------------------------------------------------+
// | onewire_pkg: state encoding, command codes and default slot timing     |
// | for the 1-Wire bit-level master.                                       |
// | rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

package onewire_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST_LOW   = 3'd1,
        ST_RST_HIGH  = 3'd2,
        ST_SLOT_LOW  = 3'd3,
        ST_SLOT_HIGH = 3'd4
    } ow_state_t;

    localparam logic [1:0] CMD_RESET = 2'b00;
    localparam logic [1:0] CMD_WR0   = 2'b01;
    localparam logic [1:0] CMD_WR1   = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    localparam int DEF_CLK_PER_US = 50;
    localparam int DEF_T_RSTL     = 480;
    localparam int DEF_T_PDS      = 70;
    localparam int DEF_T_RSTH     = 480;
    localparam int DEF_T_LOW1     = 6;
    localparam int DEF_T_LOW0     = 60;
    localparam int DEF_T_RDS      = 15;
    localparam int DEF_T_SLOT     = 70;

endpackage

`default_nettype wire

// File: rtl/onewire_tick.sv
// +------------------------------------------------------------------------+
// | onewire_tick: microsecond prescaler, pulses tick when count wraps.     |
// | rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module onewire_tick #(
    parameter int CLK_PER_US = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_PER_US > 2) ? $clog2(CLK_PER_US) : 1;
    localparam logic [CW-1:0] c_last = CW'(CLK_PER_US - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == c_last);
    assign tick   = w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/onewire_master.sv
// +------------------------------------------------------------------------+
// | onewire_master: 1-Wire bit-level master (reset/presence, write, read), |
// | open-drain pad control, microsecond slot timing.                       |
// | rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module onewire_master
    import onewire_pkg::*;
#(
    parameter int CLK_PER_US = DEF_CLK_PER_US,
    parameter int T_RSTL     = DEF_T_RSTL,
    parameter int T_PDS      = DEF_T_PDS,
    parameter int T_RSTH     = DEF_T_RSTH,
    parameter int T_LOW1     = DEF_T_LOW1,
    parameter int T_LOW0     = DEF_T_LOW0,
    parameter int T_RDS      = DEF_T_RDS,
    parameter int T_SLOT     = DEF_T_SLOT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    output logic       busy,
    output logic       rsp_valid,
    output logic       rsp_bit,
    output logic       pad_o,
    output logic       pad_t,
    input  logic       pad_i
);

    // Phase ends fire on the tick that would make us_cnt equal the target,
    // so every phase lasts exactly T*CLK_PER_US cycles.
    localparam logic [9:0] c_rstl_last = 10'(T_RSTL - 1);
    localparam logic [9:0] c_rsth_last = 10'(T_RSTH - 1);
    localparam logic [9:0] c_low0_last = 10'(T_LOW0 - 1);
    localparam logic [9:0] c_low1_last = 10'(T_LOW1 - 1);
    localparam logic [9:0] c_slot_last = 10'(T_SLOT - 1);
    localparam logic [9:0] c_pds       = 10'(T_PDS);
    localparam logic [9:0] c_rds       = 10'(T_RDS);

    ow_state_t   r_state;
    ow_state_t   w_next;
    logic [1:0]  r_cmd;
    logic [9:0]  r_us_cnt;
    logic [9:0]  w_target;
    logic        r_sync1;
    logic        r_pad_s;
    logic        r_sample;
    logic        r_rsp_valid;
    logic        r_rsp_bit;
    logic        w_tick;
    logic        w_accept;
    logic        w_done;
    logic        w_rsp_fire;
    logic        w_capture;

    assign w_accept = cmd_valid && (r_state == ST_IDLE);

    onewire_tick #(
        .CLK_PER_US (CLK_PER_US)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_accept),
        .tick  (w_tick)
    );

    always_comb begin
        w_target = '1;
        case (r_state)
            ST_RST_LOW:   w_target = c_rstl_last;
            ST_RST_HIGH:  w_target = c_rsth_last;
            ST_SLOT_LOW:  w_target = (r_cmd == CMD_WR0) ? c_low0_last : c_low1_last;
            ST_SLOT_HIGH: w_target = c_slot_last;
            default:      w_target = '1;
        endcase
    end

    assign w_done     = w_tick && (r_us_cnt == w_target);
    assign w_rsp_fire = w_done && ((r_state == ST_RST_HIGH) ||
                                   ((r_state == ST_SLOT_HIGH) && (r_cmd == CMD_READ)));
    assign w_capture  = w_tick && (((r_state == ST_RST_HIGH) && (r_us_cnt == c_pds)) ||
                                   ((r_state == ST_SLOT_HIGH) && (r_cmd == CMD_READ) &&
                                    (r_us_cnt == c_rds)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (cmd_valid) w_next = (cmd == CMD_RESET) ? ST_RST_LOW : ST_SLOT_LOW;
            ST_RST_LOW:   if (w_done) w_next = ST_RST_HIGH;
            ST_RST_HIGH:  if (w_done) w_next = ST_IDLE;
            ST_SLOT_LOW:  if (w_done) w_next = ST_SLOT_HIGH;
            ST_SLOT_HIGH: if (w_done) w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    // Pad release follows the state directly so an async reset frees the bus at once.
    always_comb begin
        pad_t     = 1'b1;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_RST_LOW, ST_SLOT_LOW: pad_t = 1'b0;
            default: pad_t = 1'b1;
        endcase
    end

    assign pad_o     = 1'b0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_bit   = r_rsp_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd    <= CMD_RESET;
            r_us_cnt <= '0;
        end else if (w_accept) begin
            r_cmd    <= cmd;
            r_us_cnt <= '0;
        end else if (w_tick && (r_state != ST_IDLE)) begin
            if ((r_state == ST_RST_LOW) && w_done) begin
                r_us_cnt <= '0;
            end else begin
                r_us_cnt <= r_us_cnt + 10'd1;
            end
        end
    end

    // The line idles high through the pull-up, so the synchronizer resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_pad_s <= 1'b1;
        end else begin
            r_sync1 <= pad_i;
            r_pad_s <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_bit   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_sample <= (r_state == ST_RST_HIGH) ? ~r_pad_s : r_pad_s;
            end
            r_rsp_valid <= w_rsp_fire;
            if (w_rsp_fire) begin
                r_rsp_bit <= r_sample;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_onewire_master.sv
// +------------------------------------------------------------------------+
// | tb_onewire_master: directed bench, CLK_PER_US=4, pull-up pad model.    |
// | rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_onewire_master;
    import onewire_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic       busy;
    logic       rsp_valid;
    logic       rsp_bit;
    logic       pad_o;
    logic       pad_t;
    logic       pad_i;
    logic       dev_low;

    int n_checks;
    int n_fail;

    // Open-drain bus: low if the master drives or the device pulls, else pull-up.
    assign pad_i = ((!pad_t && !pad_o) || dev_low) ? 1'b0 : 1'b1;

    onewire_master #(
        .CLK_PER_US (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_bit   (rsp_bit),
        .pad_o     (pad_o),
        .pad_t     (pad_t),
        .pad_i     (pad_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issues one command and watches the slot. Device pulls low for negedge
    // indices [dfrom, dto) counted from the accept edge.
    task automatic run_cmd(input logic [1:0] c, input int dfrom, input int dto,
                           input bit tog, output int low, output int bsy,
                           output int nrsp, output int rat, output int rb,
                           output int rerr);
        bit done;
        low = 0; bsy = 0; nrsp = 0; rat = -1; rb = -1; rerr = 0; done = 0;
        cmd = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int n = 1; n <= 6000; n++) begin
            dev_low = (n >= dfrom) && (n < dto);
            if (tog) begin
                cmd_valid = (n >= 10) && (n < 200) && n[0];
                cmd       = CMD_RESET;
            end
            if (!pad_t) low++;
            if (busy) bsy++;
            if ((busy && cmd_ready) || pad_o) rerr++;
            if (rsp_valid) begin
                nrsp++;
                rat = n - 1;
                rb  = int'(rsp_bit);
            end
            if (!busy) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        dev_low   = 1'b0;
        cmd_valid = 1'b0;
        check("slot_terminates", int'(done), 1);
    endtask

    initial begin
        int low, bsy, nrsp, rat, rb, rerr, extra;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd       = CMD_RESET;
        dev_low   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_pad_t", int'(pad_t), 1);
        check("rst_pad_o", int'(pad_o), 0);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_bit", int'(rsp_bit), 0);

        // Reset with a device answering 60..190 us after release (release at 1920 cycles).
        run_cmd(CMD_RESET, 1920 + 240, 1920 + 760, 0, low, bsy, nrsp, rat, rb, rerr);
        check("pres_low", low, 1920);
        check("pres_busy", bsy, 3840);
        check("pres_nrsp", nrsp, 1);
        check("pres_rsp_at", rat, 3840);
        check("pres_bit", rb, 1);
        check("pres_ready_err", rerr, 0);

        run_cmd(CMD_RESET, 0, 0, 0, low, bsy, nrsp, rat, rb, rerr);
        check("nodev_bit", rb, 0);
        check("nodev_busy", bsy, 3840);

        // Back-to-back writes: the second is offered in the first IDLE cycle.
        run_cmd(CMD_WR0, 0, 0, 0, low, bsy, nrsp, rat, rb, rerr);
        check("wr0_low", low, 240);
        check("wr0_busy", bsy, 280);
        check("wr0_nrsp", nrsp, 0);
        run_cmd(CMD_WR1, 0, 0, 0, low, bsy, nrsp, rat, rb, rerr);
        check("wr1_low", low, 24);
        check("wr1_busy", bsy, 280);
        check("wr1_nrsp", nrsp, 0);

        run_cmd(CMD_READ, 0, 120, 0, low, bsy, nrsp, rat, rb, rerr);
        check("rd0_low", low, 24);
        check("rd0_bit", rb, 0);
        check("rd0_rsp_at", rat, 280);
        run_cmd(CMD_READ, 0, 0, 0, low, bsy, nrsp, rat, rb, rerr);
        check("rd1_bit", rb, 1);
        check("rd1_rsp_at", rat, 280);

        // cmd_valid toggling with a reset code while a read is in flight.
        run_cmd(CMD_READ, 0, 120, 1, low, bsy, nrsp, rat, rb, rerr);
        check("tog_ready_err", rerr, 0);
        check("tog_busy", bsy, 280);
        check("tog_rsp_at", rat, 280);
        check("tog_bit", rb, 0);

        // Async reset 100 us into a reset pulse.
        cmd = CMD_RESET;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (399) @(negedge clk);
        check("abort_pre_pad_t", int'(pad_t), 0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_pad_t", int'(pad_t), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_rsp_valid", int'(rsp_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) extra++;
        end
        check("abort_quiet", extra, 0);
        run_cmd(CMD_RESET, 0, 0, 0, low, bsy, nrsp, rat, rb, rerr);
        check("after_abort_low", low, 1920);
        check("after_abort_busy", bsy, 3840);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
